// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : shared ALUOp encodings, opcodes and control-bundle type for the RV64 core
// Rev 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
  } ctrl_t;

  // An invalid ID slot must never carry live control into EX.
  function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic v);
    return v ? c : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// ============================================================================
// hazard_detect : combinational load-use detection between EX (load) and ID
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_detect
  import core_pkg::*;
(
  input  logic       i_valid_ex,
  input  logic       i_memread_ex,
  input  logic [4:0] i_rd_ex,
  input  logic [4:0] i_rs1_id,
  input  logic [4:0] i_rs2_id,
  input  logic       i_valid_id,
  output logic       o_load_use
);

  logic w_src_match;

  // Both sources are compared even for formats that ignore rs2: conservative.
  assign w_src_match = (i_rd_ex == i_rs1_id) | (i_rd_ex == i_rs2_id);
  assign o_load_use  = i_valid_ex & i_memread_ex & (i_rd_ex != 5'd0) & w_src_match & i_valid_id;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// ============================================================================
// id_ex_stage_reg : ID/EX pipeline register with load-use stall and bubble counting
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_id,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_id,
  input  logic             memread_id,
  input  logic             memtoreg_id,
  input  logic [1:0]       aluop_id,
  input  logic             memwrite_id,
  input  logic             alusrc_id,
  input  logic             regwrite_id,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [XLEN-1:0]  rs1_data_id,
  input  logic [XLEN-1:0]  rs2_data_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic [3:0]       funct4_id,
  output logic             branch_ex,
  output logic             memread_ex,
  output logic             memtoreg_ex,
  output logic [1:0]       aluop_ex,
  output logic             memwrite_ex,
  output logic             alusrc_ex,
  output logic             regwrite_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  rs1_data_ex,
  output logic [XLEN-1:0]  rs2_data_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic [3:0]       funct4_ex,
  output logic             valid_ex,
  output logic             stall_front,
  output logic [CNT_W-1:0] bubble_cnt
);

  ctrl_t            r_ctrl;
  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [3:0]       r_funct4;
  logic [CNT_W-1:0] r_bubble_cnt;

  ctrl_t w_ctrl_id;
  logic  w_load_use;

  assign w_ctrl_id = '{branch:   branch_id,
                       memread:  memread_id,
                       memtoreg: memtoreg_id,
                       aluop:    aluop_id,
                       memwrite: memwrite_id,
                       alusrc:   alusrc_id,
                       regwrite: regwrite_id};

  hazard_detect u_hazard_detect (
    .i_valid_ex   (r_valid),
    .i_memread_ex (r_ctrl.memread),
    .i_rd_ex      (r_rd),
    .i_rs1_id     (rs1_id),
    .i_rs2_id     (rs2_id),
    .i_valid_id   (valid_id),
    .o_load_use   (w_load_use)
  );

  assign stall_front = ~reset & (w_load_use | stall);

  // Priority: reset > stall > flush > load_use > normal load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl       <= '0;
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_funct4     <= '0;
      r_bubble_cnt <= '0;
    end else if (stall) begin
      r_bubble_cnt <= r_bubble_cnt;
    end else if (flush | w_load_use) begin
      // Bubble: kill control only; data fields are don't-care once valid drops.
      r_ctrl       <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end else begin
      r_ctrl     <= ctrl_gate(w_ctrl_id, valid_id);
      r_valid    <= valid_id;
      r_pc       <= pc_id;
      r_rs1_data <= rs1_data_id;
      r_rs2_data <= rs2_data_id;
      r_imm      <= imm_id;
      r_rs1      <= rs1_id;
      r_rs2      <= rs2_id;
      r_rd       <= rd_id;
      r_funct4   <= funct4_id;
    end
  end

  assign branch_ex   = r_ctrl.branch;
  assign memread_ex  = r_ctrl.memread;
  assign memtoreg_ex = r_ctrl.memtoreg;
  assign aluop_ex    = r_ctrl.aluop;
  assign memwrite_ex = r_ctrl.memwrite;
  assign alusrc_ex   = r_ctrl.alusrc;
  assign regwrite_ex = r_ctrl.regwrite;
  assign valid_ex    = r_valid;
  assign pc_ex       = r_pc;
  assign rs1_data_ex = r_rs1_data;
  assign rs2_data_ex = r_rs2_data;
  assign imm_ex      = r_imm;
  assign rs1_ex      = r_rs1;
  assign rs2_ex      = r_rs2;
  assign rd_ex       = r_rd;
  assign funct4_ex   = r_funct4;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
// ============================================================================
// tb_id_ex_stage_reg : scoreboard bench for id_ex_stage_reg (directed + random)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic        branch;
    logic        memread;
    logic        memtoreg;
    logic [1:0]  aluop;
    logic        memwrite;
    logic        alusrc;
    logic        regwrite;
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  f4;
  } slot_t;

  typedef struct packed {
    slot_t       st;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset, valid_id, stall, flush;
  logic branch_id, memread_id, memtoreg_id, memwrite_id, alusrc_id, regwrite_id;
  logic [1:0]  aluop_id;
  logic [63:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic [3:0]  funct4_id;

  logic branch_ex, memread_ex, memtoreg_ex, memwrite_ex, alusrc_ex, regwrite_ex;
  logic [1:0]  aluop_ex;
  logic [63:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [3:0]  funct4_ex;
  logic        valid_ex, stall_front;
  logic [31:0] bubble_cnt;

  logic b_branch_ex, b_memread_ex, b_memtoreg_ex, b_memwrite_ex, b_alusrc_ex, b_regwrite_ex;
  logic [1:0]  b_aluop_ex;
  logic [63:0] b_pc_ex, b_rs1_data_ex, b_rs2_data_ex, b_imm_ex;
  logic [4:0]  b_rs1_ex, b_rs2_ex, b_rd_ex;
  logic [3:0]  b_funct4_ex;
  logic        b_valid_ex, b_stall_front;
  logic [2:0]  b_bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id), .stall(stall), .flush(flush),
    .branch_id(branch_id), .memread_id(memread_id), .memtoreg_id(memtoreg_id),
    .aluop_id(aluop_id), .memwrite_id(memwrite_id), .alusrc_id(alusrc_id),
    .regwrite_id(regwrite_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id),
    .rs2_data_id(rs2_data_id), .imm_id(imm_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .funct4_id(funct4_id),
    .branch_ex(branch_ex), .memread_ex(memread_ex), .memtoreg_ex(memtoreg_ex),
    .aluop_ex(aluop_ex), .memwrite_ex(memwrite_ex), .alusrc_ex(alusrc_ex),
    .regwrite_ex(regwrite_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .funct4_ex(funct4_ex), .valid_ex(valid_ex),
    .stall_front(stall_front), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance: exercises counter wrap within a short run.
  id_ex_stage_reg #(.XLEN(64), .CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .valid_id(valid_id), .stall(stall), .flush(flush),
    .branch_id(branch_id), .memread_id(memread_id), .memtoreg_id(memtoreg_id),
    .aluop_id(aluop_id), .memwrite_id(memwrite_id), .alusrc_id(alusrc_id),
    .regwrite_id(regwrite_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id),
    .rs2_data_id(rs2_data_id), .imm_id(imm_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .funct4_id(funct4_id),
    .branch_ex(b_branch_ex), .memread_ex(b_memread_ex), .memtoreg_ex(b_memtoreg_ex),
    .aluop_ex(b_aluop_ex), .memwrite_ex(b_memwrite_ex), .alusrc_ex(b_alusrc_ex),
    .regwrite_ex(b_regwrite_ex), .pc_ex(b_pc_ex), .rs1_data_ex(b_rs1_data_ex),
    .rs2_data_ex(b_rs2_data_ex), .imm_ex(b_imm_ex), .rs1_ex(b_rs1_ex), .rs2_ex(b_rs2_ex),
    .rd_ex(b_rd_ex), .funct4_ex(b_funct4_ex), .valid_ex(b_valid_ex),
    .stall_front(b_stall_front), .bubble_cnt(b_bubble_cnt)
  );

  int    n_cmp  = 0;
  int    n_fail = 0;
  exp_t  sb_q[$];
  slot_t m;            // model of the instruction currently in EX
  logic [31:0] mcnt;   // model bubble count

  function automatic slot_t mk(input logic v, input logic br, input logic mr, input logic m2r,
                               input logic [1:0] op, input logic mw, input logic as,
                               input logic rw, input logic [4:0] rd, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [63:0] pc);
    slot_t s;
    s = '0;
    s.valid = v; s.branch = br; s.memread = mr; s.memtoreg = m2r; s.aluop = op;
    s.memwrite = mw; s.alusrc = as; s.regwrite = rw; s.rd = rd; s.rs1 = s1; s.rs2 = s2;
    s.pc = pc; s.rs1d = {32'h0, $urandom}; s.rs2d = {$urandom, $urandom};
    s.imm = {{32{1'b1}}, $urandom}; s.f4 = 4'($urandom);
    return s;
  endfunction

  function automatic slot_t rnd();
    slot_t s;
    s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom};
    s.rs1 = 5'($urandom_range(0, 7));
    s.rs2 = 5'($urandom_range(0, 7));
    s.rd  = 5'($urandom_range(0, 7));
    return s;
  endfunction

  // Drive one cycle of inputs, check stall_front, and queue the expected EX state.
  task automatic apply(input logic rst, input logic stl, input logic fl, input slot_t ins);
    logic  lu, exp_sf;
    @(negedge clk);
    reset = rst; stall = stl; flush = fl; valid_id = ins.valid;
    branch_id = ins.branch; memread_id = ins.memread; memtoreg_id = ins.memtoreg;
    aluop_id = ins.aluop; memwrite_id = ins.memwrite; alusrc_id = ins.alusrc;
    regwrite_id = ins.regwrite; pc_id = ins.pc; rs1_data_id = ins.rs1d;
    rs2_data_id = ins.rs2d; imm_id = ins.imm; rs1_id = ins.rs1; rs2_id = ins.rs2;
    rd_id = ins.rd; funct4_id = ins.f4;
    #1;
    lu = m.valid && m.memread && (m.rd != 5'd0) && ins.valid &&
         ((m.rd == ins.rs1) || (m.rd == ins.rs2));
    exp_sf = !rst && (lu || stl);
    n_cmp++;
    if (stall_front !== exp_sf || b_stall_front !== exp_sf) begin
      n_fail++;
      $display("FAIL stall_front t=%0t got=%b/%b exp=%b", $time, stall_front, b_stall_front, exp_sf);
    end
    if (rst) begin
      m = '0; mcnt = 0;
    end else if (stl) begin
      // everything holds
    end else if (fl || lu) begin
      m.valid = 0; m.branch = 0; m.memread = 0; m.memtoreg = 0; m.aluop = 0;
      m.memwrite = 0; m.alusrc = 0; m.regwrite = 0;
      mcnt = mcnt + 1;
    end else begin
      m = ins;
      if (!ins.valid) begin
        m.branch = 0; m.memread = 0; m.memtoreg = 0; m.aluop = 0;
        m.memwrite = 0; m.alusrc = 0; m.regwrite = 0;
      end
    end
    sb_q.push_back('{st: m, cnt: mcnt});
  endtask

  // Monitor: the register presents a fresh EX slot after every edge.
  initial begin
    exp_t  e;
    slot_t a, b;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {valid_ex, branch_ex, memread_ex, memtoreg_ex, aluop_ex, memwrite_ex, alusrc_ex,
             regwrite_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs1_ex, rs2_ex, rd_ex, funct4_ex};
        b = {b_valid_ex, b_branch_ex, b_memread_ex, b_memtoreg_ex, b_aluop_ex, b_memwrite_ex,
             b_alusrc_ex, b_regwrite_ex, b_pc_ex, b_rs1_data_ex, b_rs2_data_ex, b_imm_ex,
             b_rs1_ex, b_rs2_ex, b_rd_ex, b_funct4_ex};
        n_cmp++;
        if (a !== e.st || bubble_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL ex_slot t=%0t got=%h cnt=%0d exp=%h cnt=%0d", $time, a, bubble_cnt, e.st, e.cnt);
        end
        n_cmp++;
        if (b !== e.st || b_bubble_cnt !== e.cnt[2:0]) begin
          n_fail++;
          $display("FAIL ex_slot_narrow t=%0t got=%h cnt=%0d exp=%h cnt=%0d", $time, b, b_bubble_cnt, e.st, e.cnt[2:0]);
        end
      end
    end
  end

  initial begin
    slot_t ld, add, sd, beq, nop;
    m = '0; mcnt = 0;
    reset = 1; stall = 0; flush = 0; valid_id = 0;
    branch_id = 0; memread_id = 0; memtoreg_id = 0; aluop_id = 0; memwrite_id = 0;
    alusrc_id = 0; regwrite_id = 0; pc_id = 0; rs1_data_id = 0; rs2_data_id = 0;
    imm_id = 0; rs1_id = 0; rs2_id = 0; rd_id = 0; funct4_id = 0;
    nop = '0;

    // Reset with random inputs
    apply(1, 1'($urandom), 1'($urandom), rnd());
    apply(1, 1'($urandom), 1'($urandom), rnd());

    // R-type add x5,x1,x2
    add = mk(1, 0, 0, 0, 2'b10, 0, 0, 1, 5, 1, 2, 64'h100);
    add.rs1d = 64'hA; add.imm = 64'h0;
    apply(0, 0, 0, add);

    // ld x5 then dependent add x6,x5,x7 (presented twice: stalled then accepted)
    ld  = mk(1, 0, 1, 1, 2'b00, 0, 1, 1, 5, 2, 0, 64'h104);
    add = mk(1, 0, 0, 0, 2'b10, 0, 0, 1, 6, 5, 7, 64'h108);
    apply(0, 0, 0, ld);
    apply(0, 0, 0, add);
    apply(0, 0, 0, add);

    // ld x0 then add x6,x0,x0: no hazard
    ld  = mk(1, 0, 1, 1, 2'b00, 0, 1, 1, 0, 2, 0, 64'h10C);
    add = mk(1, 0, 0, 0, 2'b10, 0, 0, 1, 6, 0, 0, 64'h110);
    apply(0, 0, 0, ld);
    apply(0, 0, 0, add);

    // Flush a store, then stall together with flush
    sd = mk(1, 0, 0, 0, 2'b00, 1, 1, 0, 0, 3, 4, 64'h114);
    apply(0, 0, 1, sd);
    apply(0, 1, 1, sd);

    // beq held by a 3-cycle stall
    beq = mk(1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 8, 9, 64'h118);
    apply(0, 0, 0, beq);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, rnd());
    apply(0, 0, 0, nop);

    // Eight consecutive flushes wrap the narrow counter
    for (int i = 0; i < 8; i++) apply(0, 0, 1, rnd());

    // Load with reset in mid-stall
    ld = mk(1, 0, 1, 1, 2'b00, 0, 1, 1, 3, 1, 1, 64'h200);
    apply(0, 0, 0, ld);
    apply(0, 1, 0, rnd());
    apply(1, 1, 0, rnd());
    apply(0, 0, 0, add);

    // Random traffic, biased toward loads and small register numbers
    for (int i = 0; i < 400; i++) begin
      slot_t r;
      r = rnd();
      r.memread = ($urandom_range(0, 1) == 1);
      r.valid   = ($urandom_range(0, 9) != 0);
      apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10), r);
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
